// File: rtl/pipe_stall_ctrl.sv
// Hazard/stall controller for the 5-stage pipeline: priority stall vector, wrong-path
// fetch discard tracking and stall watchdog. Define STALL_PERF_EN for per-state cycle counters.
module pipe_stall_ctrl #(
  parameter int MAX_WAIT = 64,
  parameter int CNT_W    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_stall_req,
  input  logic        id_stall_req,
  input  logic        mem_stall_req,
  input  logic        ex_b_flag,
  output logic [5:0]  stall,
  output logic        if_discard,
  output logic        hang_err,
  output logic [2:0]  ctrl_state
`ifdef STALL_PERF_EN
  ,
  output logic [31:0] perf_mem_cyc,
  output logic [31:0] perf_lu_cyc,
  output logic [31:0] perf_if_cyc
`endif
);

  typedef enum logic [2:0] {
    RUN       = 3'd0,
    IF_WAIT   = 3'd1,
    LU_BUBBLE = 3'd2,
    MEM_WAIT  = 3'd3,
    REDIRECT  = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

  state_e           state_q, state_d;
  logic             pend_q, pend_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hang_q, hang_d;
  logic [5:0]       stall_raw;

  always_comb begin
    stall_raw = 6'b000000;
    if (mem_stall_req)     stall_raw = 6'b011111;
    else if (id_stall_req) stall_raw = 6'b000111;
    else if (if_stall_req) stall_raw = 6'b000011;
  end

  // Reset must take the stall vector down immediately, not at the next edge.
  assign stall      = rst ? stall_raw : 6'b000000;
  assign if_discard = rst & pend_q & ~if_stall_req;
  assign hang_err   = hang_q;
  assign ctrl_state = state_q;

  // A branch during a MEM stall is re-presented later, so it cannot arm the discard.
  always_comb begin
    pend_d = pend_q;
    if (pend_q && !if_stall_req)
      pend_d = 1'b0;
    else if (ex_b_flag && !mem_stall_req && if_stall_req)
      pend_d = 1'b1;
  end

  always_comb begin
    state_d = RUN;
    if (mem_stall_req)     state_d = MEM_WAIT;
    else if (id_stall_req) state_d = LU_BUBBLE;
    else if (if_stall_req) state_d = pend_d ? REDIRECT : IF_WAIT;
  end

  always_comb begin
    cnt_d = '0;
    if (stall != 6'b000000)
      cnt_d = (cnt_q == MAX_CNT) ? cnt_q : cnt_q + 1'b1;
    hang_d = hang_q | (cnt_d == MAX_CNT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      pend_q  <= 1'b0;
      cnt_q   <= '0;
      hang_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      hang_q  <= hang_d;
    end
  end

`ifdef STALL_PERF_EN
  logic [31:0] pmem_q, plu_q, pif_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pmem_q <= '0;
      plu_q  <= '0;
      pif_q  <= '0;
    end else begin
      if (state_q == MEM_WAIT)  pmem_q <= pmem_q + 32'd1;
      if (state_q == LU_BUBBLE) plu_q  <= plu_q + 32'd1;
      if (state_q == IF_WAIT || state_q == REDIRECT) pif_q <= pif_q + 32'd1;
    end
  end

  assign perf_mem_cyc = pmem_q;
  assign perf_lu_cyc  = plu_q;
  assign perf_if_cyc  = pif_q;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl (MAX_WAIT=4): stall priority, FSM, discard, watchdog, reset.
module tb_pipe_stall_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic       if_req, id_req, mem_req, exb;
  logic [5:0] stall;
  logic       disc, hang;
  logic [2:0] cs;
`ifdef STALL_PERF_EN
  logic [31:0] pmem, plu, pif;
`endif
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_stall_ctrl #(.MAX_WAIT(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .if_stall_req(if_req), .id_stall_req(id_req), .mem_stall_req(mem_req),
    .ex_b_flag(exb), .stall(stall), .if_discard(disc), .hang_err(hang),
    .ctrl_state(cs)
`ifdef STALL_PERF_EN
    , .perf_mem_cyc(pmem), .perf_lu_cyc(plu), .perf_if_cyc(pif)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [5:0] st, input logic [2:0] s,
                         input logic d, input logic h);
    chk({tag, "_stall"}, 32'(stall), 32'(st));
    chk({tag, "_state"}, 32'(cs), 32'(s));
    chk({tag, "_disc"},  32'(disc), 32'(d));
    chk({tag, "_hang"},  32'(hang), 32'(h));
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Inputs change at posedge+1, outputs are sampled at posedge+2.
  task automatic cyc(input logic m, input logic i, input logic f, input logic b);
    mem_req = m; id_req = i; if_req = f; exb = b;
    #1;
  endtask

  initial begin
    rst = 1'b0;
    mem_req = 1'b1; id_req = 1'b0; if_req = 1'b0; exb = 1'b0;
    #2;
    chk_all("in_reset", 6'h00, 3'd0, 1'b0, 1'b0);
    mem_req = 1'b0;
    #1 rst = 1'b1;
    tick;
    for (int k = 0; k < 5; k++) begin
      cyc(0, 0, 0, 0); chk_all("idle", 6'h00, 3'd0, 1'b0, 1'b0); tick;
    end

    // single-cycle load-use
    cyc(0, 1, 0, 0); chk_all("id_c1", 6'h07, 3'd0, 1'b0, 1'b0); tick;
    cyc(0, 0, 0, 0); chk_all("id_c2", 6'h00, 3'd2, 1'b0, 1'b0); tick;
    cyc(0, 0, 0, 0); chk_all("id_c3", 6'h00, 3'd0, 1'b0, 1'b0); tick;

    // MEM masks ID; 3 stalled cycles stays below the watchdog limit
    for (int k = 0; k < 3; k++) begin
      cyc(1, 1, 0, 0); chk_all("memid", 6'h1f, (k == 0) ? 3'd0 : 3'd3, 1'b0, 1'b0); tick;
    end
    cyc(0, 0, 0, 0); chk_all("memid_end", 6'h00, 3'd3, 1'b0, 1'b0); tick;
    cyc(0, 0, 0, 0); chk_all("memid_run", 6'h00, 3'd0, 1'b0, 1'b0); tick;

    // branch redirect during fetch stall; 4 stalled cycles also trips the watchdog
    cyc(0, 0, 1, 0); chk_all("rd_c1", 6'h03, 3'd0, 1'b0, 1'b0); tick;
    cyc(0, 0, 1, 1); chk_all("rd_c2", 6'h03, 3'd1, 1'b0, 1'b0); tick;
    cyc(0, 0, 1, 0); chk_all("rd_c3", 6'h03, 3'd4, 1'b0, 1'b0); tick;
    cyc(0, 0, 1, 0); chk_all("rd_c4", 6'h03, 3'd4, 1'b0, 1'b0); tick;
    cyc(0, 0, 0, 0); chk_all("rd_c5", 6'h00, 3'd4, 1'b1, 1'b1); tick;
    cyc(0, 0, 0, 0); chk_all("rd_c6", 6'h00, 3'd0, 1'b0, 1'b1); tick;

    // branch under MEM stall is ignored
    cyc(1, 0, 1, 1); chk_all("bm_c1", 6'h1f, 3'd0, 1'b0, 1'b1); tick;
    cyc(0, 0, 1, 0); chk_all("bm_c2", 6'h03, 3'd3, 1'b0, 1'b1); tick;
    cyc(0, 0, 0, 0); chk_all("bm_c3", 6'h00, 3'd1, 1'b0, 1'b1); tick;
    cyc(0, 0, 0, 0); chk_all("bm_c4", 6'h00, 3'd0, 1'b0, 1'b1); tick;

    // asynchronous reset in the middle of a MEM stall
    cyc(1, 0, 0, 0); tick;
    cyc(1, 0, 0, 0); chk_all("pre_arst", 6'h1f, 3'd3, 1'b0, 1'b1);
    rst = 1'b0;
    #1 chk_all("arst", 6'h00, 3'd0, 1'b0, 1'b0);
    tick;
    mem_req = 1'b0; rst = 1'b1;
    cyc(0, 0, 0, 0); chk_all("post_arst", 6'h00, 3'd0, 1'b0, 1'b0); tick;

    // watchdog: hang rises after the 4th stalled cycle and is sticky
    for (int k = 1; k <= 10; k++) begin
      cyc(1, 0, 0, 0); chk("wd_hang", 32'(hang), (k >= 5) ? 32'd1 : 32'd0); tick;
    end
    cyc(0, 0, 0, 0); chk("wd_sticky1", 32'(hang), 32'd1); tick;
    cyc(0, 0, 0, 0); chk("wd_sticky2", 32'(hang), 32'd1);
    rst = 1'b0;
    #1 chk("wd_rst_clear", 32'(hang), 32'd0);
    tick;
    rst = 1'b1;

    // second branch while pending yields a single discard pulse
    cyc(0, 0, 1, 1); chk_all("db_c1", 6'h03, 3'd0, 1'b0, 1'b0); tick;
    cyc(0, 0, 1, 1); chk_all("db_c2", 6'h03, 3'd4, 1'b0, 1'b0); tick;
    cyc(0, 0, 1, 0); chk_all("db_c3", 6'h03, 3'd4, 1'b0, 1'b0); tick;
    cyc(0, 0, 0, 0); chk_all("db_c4", 6'h00, 3'd4, 1'b1, 1'b0); tick;
    cyc(0, 0, 0, 0); chk_all("db_c5", 6'h00, 3'd0, 1'b0, 1'b0); tick;

    // branch without a fetch stall issues no discard
    cyc(0, 0, 0, 1); chk_all("nb_c1", 6'h00, 3'd0, 1'b0, 1'b0); tick;
    cyc(0, 0, 0, 0); chk_all("nb_c2", 6'h00, 3'd0, 1'b0, 1'b0); tick;

`ifdef STALL_PERF_EN
    rst = 1'b0;
    #2 rst = 1'b1;
    tick;
    for (int k = 0; k < 7; k++) begin
      cyc(1, 0, 0, 0); tick;
    end
    cyc(0, 0, 0, 0); tick;
    cyc(0, 0, 0, 0);
    chk("perf_mem", pmem, 32'd7);
    chk("perf_lu",  plu,  32'd0);
    chk("perf_if",  pif,  32'd0);
    tick;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
